data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_pkg.sv | 19 +
 rtl/data_memory_responder_if.sv | 31 +++
 rtl/dmem_array.sv | 45 ++++
 rtl/data_memory_responder.sv | 137 +++++++++++++
 tb/tb_data_memory_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the data memory responder slice.
//   state_t           : responder FSM states (IDLE, WAIT, RESP)
//   WORD_WIDTH        : data/address word width in bits
//   DEFAULT_BASE_ADDR : default byte address of memory word 0
// ---------------------------------------------------------------------------
package data_memory_pkg;

    localparam int          WORD_WIDTH        = 32;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// ---------------------------------------------------------------------------
// data_memory_responder_if
// Request/response bus between an initiator and the data memory responder.
//   Req_i, Write_i, Address_i, Write_Data_i, Byte_En_i : initiator -> responder
//   Ack_o, Read_Data_o, Error_o, Busy_o                 : responder -> initiator
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface data_memory_responder_if;
    import data_memory_pkg::*;

    logic                  Req_i;
    logic                  Write_i;
    logic [WORD_WIDTH-1:0] Address_i;
    logic [WORD_WIDTH-1:0] Write_Data_i;
    logic [3:0]            Byte_En_i;
    logic                  Ack_o;
    logic [WORD_WIDTH-1:0] Read_Data_o;
    logic                  Error_o;
    logic                  Busy_o;

    modport master (
        output Req_i, Write_i, Address_i, Write_Data_i, Byte_En_i,
        input  Ack_o, Read_Data_o, Error_o, Busy_o
    );

    modport slave (
        input  Req_i, Write_i, Address_i, Write_Data_i, Byte_En_i,
        output Ack_o, Read_Data_o, Error_o, Busy_o
    );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit single-port storage, synchronous byte-enabled write,
// combinational read. Contents have no reset.
//   clk   : clock
//   we    : write enable (commit on rising edge)
//   be    : byte lane enables, bit n -> bits [8n+7:8n]
//   addr  : word index
//   wdata : write data
//   rdata : word at addr (combinational)
// ---------------------------------------------------------------------------
module dmem_array
    import data_memory_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] lane_mask;

    // Expand byte enables into a bit mask so the write is a single
    // read-modify-write of the addressed word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{be[gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~lane_mask) | (wdata & lane_mask);
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Word-addressed data memory that answers one request at a time with a
// programmable number of wait states and a one-cycle Ack_o pulse.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : data_memory_responder_if.slave (request in, response out)
// Optional feature: define DMEM_RESP_ERROR_CHECK_EN to flag misaligned and
// out-of-range accesses with Error_o; otherwise the index wraps modulo depth.
// ---------------------------------------------------------------------------
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int          DATA_MEMORY_DEPTH = 128,
    parameter int          WAIT_STATES       = 2,
    parameter logic [31:0] BASE_ADDR         = DEFAULT_BASE_ADDR
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);

    localparam int         AW        = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state_reg, state_next;
    logic [3:0]            count_reg, count_next;
    logic                  write_reg;
    logic [WORD_WIDTH-1:0] addr_reg;
    logic [WORD_WIDTH-1:0] wdata_reg;
    logic [3:0]            be_reg;

    // In IDLE the live inputs describe the transfer being accepted; later
    // the latched copy does. With zero wait states the store commits on the
    // accepting edge itself, so it must see the live inputs.
    logic                  eff_write;
    logic [WORD_WIDTH-1:0] eff_addr;
    logic [WORD_WIDTH-1:0] eff_wdata;
    logic [3:0]            eff_be;
    logic [WORD_WIDTH-1:0] addr_offset;
    logic [29:0]           word_index;
    logic [AW-1:0]         mem_index;
    logic                  fault;
    logic                  enter_resp;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  unused_bits;

    assign eff_write   = (state_reg == IDLE) ? bus.Write_i      : write_reg;
    assign eff_addr    = (state_reg == IDLE) ? bus.Address_i    : addr_reg;
    assign eff_wdata   = (state_reg == IDLE) ? bus.Write_Data_i : wdata_reg;
    assign eff_be      = (state_reg == IDLE) ? bus.Byte_En_i    : be_reg;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge indices.
    assign addr_offset = eff_addr - BASE_ADDR;
    assign word_index  = addr_offset[31:2];

`ifdef DMEM_RESP_ERROR_CHECK_EN
    assign fault       = (eff_addr[1:0] != 2'b00) ||
                         ({2'b00, word_index} >= 32'(DATA_MEMORY_DEPTH));
    assign mem_index   = word_index[AW-1:0];
    assign unused_bits = ^addr_offset[1:0];
`else
    logic [31:0] wrapped_index;
    assign fault         = 1'b0;
    assign wrapped_index = {2'b00, word_index} % 32'(DATA_MEMORY_DEPTH);
    assign mem_index     = wrapped_index[AW-1:0];
    assign unused_bits   = ^{addr_offset[1:0], wrapped_index};
`endif

    // State register and request latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
        if (state_reg == IDLE && bus.Req_i) begin
            write_reg <= bus.Write_i;
            addr_reg  <= bus.Address_i;
            wdata_reg <= bus.Write_Data_i;
            be_reg    <= bus.Byte_En_i;
        end
    end

    // Next-state logic. RESP always returns to IDLE without looking at Req_i.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (bus.Req_i) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stores commit on the edge that enters RESP; a reset on that edge
    // abandons the transfer.
    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign mem_we     = reset && enter_resp && eff_write && !fault;

    dmem_array #(
        .DEPTH (DATA_MEMORY_DEPTH),
        .AW    (AW)
    ) u_dmem_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (eff_be),
        .addr  (mem_index),
        .wdata (eff_wdata),
        .rdata (mem_rdata)
    );

    assign bus.Ack_o       = (state_reg == RESP);
    assign bus.Busy_o      = (state_reg != IDLE);
    assign bus.Error_o     = (state_reg == RESP) && fault;
    assign bus.Read_Data_o = ((state_reg == RESP) && !write_reg && !fault) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
// Directed bench for data_memory_responder: one instance with the default
// two wait states and one with zero wait states, sharing the request fields.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        sel;      // 0: two-wait-state DUT, 1: zero-wait-state DUT
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;

    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_memory_responder_if if2 ();
    data_memory_responder_if if0 ();

    assign if2.Req_i        = req & ~sel;
    assign if2.Write_i      = wr;
    assign if2.Address_i    = addr;
    assign if2.Write_Data_i = wdata;
    assign if2.Byte_En_i    = ben;
    assign if0.Req_i        = req & sel;
    assign if0.Write_i      = wr;
    assign if0.Address_i    = addr;
    assign if0.Write_Data_i = wdata;
    assign if0.Byte_En_i    = ben;

    assign ack   = sel ? if0.Ack_o       : if2.Ack_o;
    assign err   = sel ? if0.Error_o     : if2.Error_o;
    assign busy  = sel ? if0.Busy_o      : if2.Busy_o;
    assign rdata = sel ? if0.Read_Data_o : if2.Read_Data_o;

    data_memory_responder #(
        .DATA_MEMORY_DEPTH (128),
        .WAIT_STATES       (2),
        .BASE_ADDR         (32'h1001_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    data_memory_responder #(
        .DATA_MEMORY_DEPTH (128),
        .WAIT_STATES       (0),
        .BASE_ADDR         (32'h1001_0000)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer: present the request at the start of a cycle, scramble the
    // fields after acceptance, wait (bounded) for Ack_o, then step back to IDLE.
    // lat counts cycles from the accepting IDLE cycle to the Ack_o cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd,
                        output logic er, output int lat);
        wr = w; addr = a; wdata = d; ben = be; req = 1'b1;
        step();
        req = 1'b0; wr = ~w; addr = 32'hFFFF_FFFF; wdata = 32'h0F0F_0F0F; ben = 4'hF;
        lat = 1;
        while (!ack && lat < 20) begin
            step();
            lat++;
        end
        rd = rdata;
        er = err;
        step();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acks;

    initial begin
        reset = 1'b0; req = 1'b0; sel = 1'b0;
        wr = 1'b0; addr = '0; wdata = '0; ben = '0;

        // Reset state.
        repeat (3) step();
        chk("rst_ack",   32'(ack),  32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err),  32'd0);
        chk("rst_rdata", rdata,     32'd0);

        // Request in the very first cycle after reset release is accepted.
        reset = 1'b1;
        xfer(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("st_full_lat", 32'(lat), 32'd3);
        chk("st_full_err", 32'(er),  32'd0);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("ld_full_lat",  32'(lat), 32'd3);
        chk("ld_full_data", rd,       32'hDEAD_BEEF);
        chk("ld_full_err",  32'(er),  32'd0);
        chk("idle_rdata",   rdata,    32'd0);

        // Single-lane store.
        xfer(1'b1, 32'h1001_0004, 32'h0000_00AA, 4'b0001, rd, er, lat);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("ld_lane0", rd, 32'hDEAD_BEAA);

        // Upper two lanes only.
        xfer(1'b1, 32'h1001_0004, 32'h1234_5678, 4'b1100, rd, er, lat);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("ld_lane23", rd, 32'h1234_BEAA);

        // No lanes enabled: acknowledged, nothing written.
        xfer(1'b1, 32'h1001_0004, 32'h5555_5555, 4'b0000, rd, er, lat);
        chk("st_be0_lat", 32'(lat), 32'd3);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("ld_be0", rd, 32'h1234_BEAA);

        // First and last words.
        xfer(1'b1, 32'h1001_0000, 32'h1122_3344, 4'hF, rd, er, lat);
        xfer(1'b1, 32'h1001_01FC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        xfer(1'b0, 32'h1001_0000, 32'h0, 4'h0, rd, er, lat);
        chk("ld_word0", rd, 32'h1122_3344);
        xfer(1'b0, 32'h1001_01FC, 32'h0, 4'h0, rd, er, lat);
        chk("ld_word127", rd, 32'hCAFE_F00D);
        chk("ld_word127_err", 32'(er), 32'd0);

`ifdef DMEM_RESP_ERROR_CHECK_EN
        xfer(1'b0, 32'h1001_0002, 32'h0, 4'h0, rd, er, lat);
        chk("misalign_err",   32'(er), 32'd1);
        chk("misalign_rdata", rd,      32'd0);
        xfer(1'b0, 32'h1001_0200, 32'h0, 4'h0, rd, er, lat);
        chk("range_err",   32'(er), 32'd1);
        chk("range_rdata", rd,      32'd0);
        xfer(1'b0, 32'h1000_FFFC, 32'h0, 4'h0, rd, er, lat);
        chk("below_err", 32'(er), 32'd1);
        xfer(1'b1, 32'h1001_0200, 32'hBAD0_BAD0, 4'hF, rd, er, lat);
        chk("st_range_err", 32'(er), 32'd1);
        xfer(1'b1, 32'h1001_0006, 32'hBAD1_BAD1, 4'hF, rd, er, lat);
        chk("st_misalign_err", 32'(er), 32'd1);
        xfer(1'b0, 32'h1001_0000, 32'h0, 4'h0, rd, er, lat);
        chk("unchanged_w0", rd, 32'h1122_3344);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("unchanged_w1", rd, 32'h1234_BEAA);
`else
        // Index wraps modulo depth and the low address bits are ignored.
        xfer(1'b0, 32'h1001_0200, 32'h0, 4'h0, rd, er, lat);
        chk("wrap_data", rd,      32'h1122_3344);
        chk("wrap_err",  32'(er), 32'd0);
        xfer(1'b0, 32'h1001_0006, 32'h0, 4'h0, rd, er, lat);
        chk("lowbits_data", rd,      32'h1234_BEAA);
        chk("lowbits_err",  32'(er), 32'd0);
`endif

        // Reset in the last WAIT cycle, where the store would otherwise commit.
        wr = 1'b1; addr = 32'h1001_0004; wdata = 32'h5555_5555; ben = 4'hF; req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("rstwait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        chk("rstwait_ack_dur",  32'(ack),  32'd0);
        chk("rstwait_busy_dur", 32'(busy), 32'd0);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack) acks++;
        end
        chk("rstwait_no_ack", 32'(acks), 32'd0);
        xfer(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        chk("rstwait_old_data", rd, 32'h1234_BEAA);

        // Back-to-back loads with Req_i held for 12 cycles.
        wr = 1'b0; addr = 32'h1001_0004; wdata = '0; ben = '0; req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("b2b_ack_%0d", k),  32'(ack),  32'((k % 4) == 3));
            chk($sformatf("b2b_busy_%0d", k), 32'(busy), 32'((k % 4) != 0));
            if ((k % 4) == 3) chk($sformatf("b2b_data_%0d", k), rdata, 32'h1234_BEAA);
        end
        req = 1'b0;
        step();
        chk("b2b_stop_busy", 32'(busy), 32'd0);

        // Zero-wait-state instance.
        sel = 1'b1;
        xfer(1'b1, 32'h1001_0010, 32'hA5A5_A5A5, 4'hF, rd, er, lat);
        chk("w0_st_lat", 32'(lat), 32'd1);
        xfer(1'b0, 32'h1001_0010, 32'h0, 4'h0, rd, er, lat);
        chk("w0_ld_lat",  32'(lat), 32'd1);
        chk("w0_ld_data", rd,       32'hA5A5_A5A5);
        chk("w0_ld_err",  32'(er),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
